// File: rtl/ha_pair_rr_scheduler_if.sv
// ha_pair_rr_scheduler_if: requester operand handshake plus result handshake of the RR AND/XOR scheduler
interface ha_pair_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 1,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic               res_valid;
  logic               res_ready;
  logic [DW-1:0]      res_and;
  logic [DW-1:0]      res_xor;
  logic [IDW-1:0]     res_id;
  logic               busy;
  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_and, res_xor, res_id, busy
  );
  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_and, res_xor, res_id, busy
  );
endinterface

// File: rtl/ha_pair_rr_scheduler.sv
// ha_pair_rr_scheduler: round-robin arbiter feeding one registered AND/XOR pair, single-entry result slot.
// Define HA_SCHED_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module ha_pair_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 1,
  parameter int IDW  = 2,
  parameter int CW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ha_pair_rr_scheduler_if.slave    bus
`ifdef HA_SCHED_STATS_EN
  ,
  output logic [NREQ*CW-1:0]       grant_cnt
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [DW-1:0]   r_and;
  logic [DW-1:0]   r_xor;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_free;
  logic            w_xfer;
  logic [DW-1:0]   w_x;
  logic [DW-1:0]   w_y;
  if (NREQ < 2 || IDW < $clog2(NREQ) || CW < 1) begin : g_bad_cfg
    $error("ha_pair_rr_scheduler: invalid NREQ/IDW/CW");
  end
  assign w_free = (r_state == EMPTY) || bus.res_ready;
  // Scan from farthest to nearest so the last hit is the first valid at or after r_ptr.
  always_comb begin
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(r_ptr) + k) % NREQ]) w_idx = IDW'((int'(r_ptr) + k) % NREQ);
  end
  // Gated by rst_n so no requester is accepted while reset is asserted.
  assign w_gnt         = (rst_n && w_free && |bus.req_valid) ? NREQ'(1) << w_idx : '0;
  assign w_xfer        = |w_gnt;
  assign w_x           = bus.req_x[w_idx*DW +: DW];
  assign w_y           = bus.req_y[w_idx*DW +: DW];
  assign bus.req_ready = w_gnt;
  assign bus.res_valid = (r_state == FULL);
  assign bus.res_and   = r_and;
  assign bus.res_xor   = r_xor;
  assign bus.res_id    = r_id;
  assign bus.busy      = (r_state == FULL) || |bus.req_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_id    <= '0;
      r_and   <= '0;
      r_xor   <= '0;
    end else if (w_xfer) begin
      r_state <= FULL;
      r_and   <= w_x & w_y;
      r_xor   <= w_x ^ w_y;
      r_id    <= w_idx;
      r_ptr   <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end else if (bus.res_ready) begin
      r_state <= EMPTY;
    end
  end
`ifdef HA_SCHED_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (w_gnt[g] && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    assign grant_cnt[g*CW +: CW] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_ha_pair_rr_scheduler.sv
// tb_ha_pair_rr_scheduler: directed and randomized checks of the RR AND/XOR scheduler against a rule-level model.
module tb_ha_pair_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 1;
  localparam int IDW  = 2;
  localparam int CW   = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  ha_pair_rr_scheduler_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();
`ifdef HA_SCHED_STATS_EN
  logic [NREQ*CW-1:0] grant_cnt;
`endif
  ha_pair_rr_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef HA_SCHED_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  bit            m_valid;
  logic [DW-1:0] m_and, m_xor;
  int            m_id, m_ptr;
  int            m_cnt [NREQ];
  logic [NREQ-1:0] hold;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr = 0;
    hold = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask
  task automatic cycle();
    int g;
    logic [NREQ-1:0] er;
    logic [DW-1:0] x, y;
    #1;
    g = -1;
    if (!m_valid || bus.res_ready)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("res_valid", bus.res_valid, m_valid);
    chk("busy", bus.busy, m_valid | (|bus.req_valid));
    if (m_valid) begin
      chk("res_and", bus.res_and, m_and);
      chk("res_xor", bus.res_xor, m_xor);
      chk("res_id", bus.res_id, m_id);
    end
`ifdef HA_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("grant_cnt", grant_cnt[i*CW +: CW], m_cnt[i]);
`endif
    if (g >= 0) begin
      x = bus.req_x[g*DW +: DW];
      y = bus.req_y[g*DW +: DW];
      m_valid = 1'b1;
      m_and = x & y;
      m_xor = x ^ y;
      m_id = g;
      m_ptr = (g + 1) % NREQ;
      if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    hold = bus.req_valid & ~er;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive_random();
    for (int i = 0; i < NREQ; i++)
      if (!hold[i]) begin
        bus.req_valid[i] = ($urandom_range(0, 2) != 0);
        bus.req_x[i*DW +: DW] = DW'($urandom);
        bus.req_y[i*DW +: DW] = DW'($urandom);
      end
    bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask
  initial begin
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    bus.req_x = NREQ*DW'($urandom);
    bus.req_y = NREQ*DW'($urandom);
    model_reset();
    #2;
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_and", bus.res_and, '0);
    chk("rst_res_xor", bus.res_xor, '0);
    chk("rst_res_id", bus.res_id, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("first_grant", bus.req_ready, 4'b0001);
    repeat (5) cycle();
    bus.req_valid = 4'b0100;
    bus.req_x = 4'b0100;
    bus.req_y = 4'b0100;
    cycle();
    bus.req_valid = '0;
    #1;
    chk("one_res_and", bus.res_and, 1'b1);
    chk("one_res_xor", bus.res_xor, 1'b0);
    chk("one_res_id", bus.res_id, 2'd2);
    cycle();
    bus.req_valid = '1;
    #1 chk("ptr_after_2", bus.req_ready, 4'b1000);
    cycle();
    bus.res_ready = 1'b0;
    repeat (5) cycle();
    bus.res_ready = 1'b1;
    #1 chk("drain_and_grant", bus.req_ready, 4'b0001);
    cycle();
    rst_n = 1'b0;
    #1 chk("async_rst_valid", bus.res_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b1;
    repeat (5) cycle();
`ifdef HA_SCHED_STATS_EN
    #1 chk("stats_sat", grant_cnt, {2'd0, 2'd0, 2'd3, 2'd0});
`endif
    bus.req_valid = '0;
    cycle();
    repeat (2000) begin
      drive_random();
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
